line_mem_responder: RTL
=======================

# line_mem_responder

Line-granular main-memory responder that serves a cache's miss/write-back port: it accepts one line-read or line-write request at a time, spends a fixed access latency, then pulses a one-cycle grant. It sits below the cache controller and is the memory-side end of the `gnt`/`addr`/`rd_req`/`rd_line`/`wr_req`/`wr_line` interface. Storage is an internal array of `2^ADDR_LEN` lines, each `2^LINE_ADDR_LEN` 32-bit words.

## Interface

**Parameters**
- `LINE_ADDR_LEN`, default 3: log2 of the number of words per line. `LINE_SIZE = 1 << LINE_ADDR_LEN`.
- `ADDR_LEN`, default 9: line-address width. Memory holds `2^ADDR_LEN` lines.
- `LATENCY`, default 4: cycles from request sample to `gnt`. Legal values are 1 or more.

**Ports** (one clock; reset is asynchronous and active-low)
- `clk`, input, 1: sole clock; everything is rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `addr`, input, ADDR_LEN: line address of the request.
- `rd_req`, input, 1: line-read request, held level by the requester until it sees `gnt`.
- `wr_req`, input, 1: line-write request, held level by the requester until it sees `gnt`.
- `wr_line`, input, 32 x LINE_SIZE (unpacked array): line to write.
- `gnt`, output, 1: one-cycle completion pulse.
- `rd_line`, output, 32 x LINE_SIZE (unpacked array): registered read data.

## Operation

**Reset (`rst_n` = 0, asynchronous)**
- State goes to IDLE; counter = 0; `gnt` = 0; every `rd_line` word = 0.
- Memory is initialised to `mem[a][w] = (a << LINE_ADDR_LEN) | w`.
- Any pending operation is discarded, including an uncommitted write.

**FSM states**
- IDLE
  - If `wr_req` or `rd_req` is sampled high: latch the operation, `addr`, and `wr_line` (write only).
  - If `LATENCY` = 1, go straight to GRANT. Otherwise set counter = `LATENCY`-2 and go to BUSY.
  - If both requests are high, treat it as a write and ignore the read (protocol violation).
- BUSY
  - Decrement the counter each cycle.
  - On the edge where counter = 0, go to GRANT.
  - On that same edge, a read loads `rd_line` from `mem[latched addr]`.
- GRANT
  - `gnt` = 1 for exactly this cycle.
  - A write commits the latched line to `mem[latched addr]` on the closing edge of this cycle.
  - Next state is IDLE.

**Operand and data rules**
- Operands are latched, so input changes after the sampling edge have no effect.
- A request that drops during BUSY still completes and still produces `gnt`.
- `rd_line` changes only when a read enters GRANT. It holds its value through writes and idle periods, so the requester may sample it in the cycle after `gnt`.
- No address arithmetic; `addr` indexes lines directly.
- Requests are not accepted in BUSY or GRANT.

## Timing

- Request high in cycle 0 (sampled at the end of cycle 0): `gnt` is high in cycle `LATENCY` and `rd_line` is valid from cycle `LATENCY` onward.
- The requester drops or changes its request on the edge where it sees `gnt`. IDLE in cycle `LATENCY`+1 may therefore accept a new request immediately; there is no dead cycle.
  - Write-back followed by refill: second `gnt` at cycle 2·`LATENCY`+1.
- `gnt` is never high on two consecutive cycles for the same operation. With `LATENCY` = 1 and back-to-back requests, `gnt` occurs every other cycle.
- Written data is readable by any read sampled after the GRANT cycle of the write.
- Reset asserted in any state forces `gnt` = 0 and `rd_line` = 0 immediately. Operation resumes in IDLE on the first edge after `rst_n` rises.

## Test plan

Defaults `LINE_ADDR_LEN`=3, `ADDR_LEN`=9, `LATENCY`=4 unless stated.

- **Read after reset:** release reset, then `rd_req`=1 with `addr`=5 in cycle 0 → `gnt`=1 only in cycle 4; `rd_line[w]` = 40+w (0x28..0x2F), held until the next read.
- **Write then read back:** write `addr`=0x1A3 with `wr_line[w]`=0xA000_0000+w → `gnt` in cycle 4, `rd_line` unchanged. Then read 0x1A3 → returns 0xA000_0000..0xA000_0007. Other lines are untouched: 0x1A2 word 0 reads 0xD10.
- **Swap sequence:** write `addr`=7, then `rd_req` on `addr`=9 starting the cycle after the first `gnt` → `gnt` pulses in cycles 4 and 9; `rd_line[w]` = 72+w; then reading line 7 returns the written data.
- **Dropped request:** `wr_req` high for 1 cycle only (`addr`=3, `wr_line`=0x55 in every word) → `gnt` still in cycle 4; a later read of line 3 returns 0x55 in every word.
- **Reset mid-operation:** assert reset in cycle 2 of a write to line 10 → `gnt` = 0 and `rd_line` = 0 at once; after release, reading line 10 gives the init pattern 80..87.
- **`LATENCY`=1 back-to-back reads** of lines 1 then 2 → `gnt` in cycles 1 and 3; `rd_line` = 8..15, then 16..23.

Source files
------------

// File: rtl/line_mem_responder.sv
// Line-granular main-memory responder: one line read or write at a time,
// fixed access latency, then a one-cycle grant pulse.
module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int LATENCY       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [31:0]         wr_line [1 << LINE_ADDR_LEN],
  output logic                gnt,
  output logic [31:0]         rd_line [1 << LINE_ADDR_LEN]
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int NUM_LINES = 1 << ADDR_LEN;
  localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_GRANT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                gnt_q, gnt_d;
  logic [31:0]         wline_q [LINE_SIZE];
  logic [31:0]         rd_line_q [LINE_SIZE];
  logic [31:0]         mem_q [NUM_LINES][LINE_SIZE];

  logic                latch_wline_s;
  logic                rd_load_s;
  logic                wr_commit_s;
  logic [ADDR_LEN-1:0] rd_addr_s;

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic; with LATENCY of 1 a read is fetched straight from the live address
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    latch_wline_s = 1'b0;
    rd_load_s     = 1'b0;
    wr_commit_s   = 1'b0;
    rd_addr_s     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (wr_req || rd_req) begin
          is_wr_d       = wr_req;
          addr_d        = addr;
          latch_wline_s = wr_req;
          if (LATENCY == 1) begin
            state_d   = S_GRANT;
            rd_load_s = !wr_req;
            rd_addr_s = addr;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d   = S_GRANT;
          rd_load_s = !is_wr_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GRANT: begin
        state_d     = S_IDLE;
        wr_commit_s = is_wr_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    gnt_d = (state_d == S_GRANT);
  end

  // Write-data latch and registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < LINE_SIZE; w++) begin
        wline_q[w]   <= 32'h0000_0000;
        rd_line_q[w] <= 32'h0000_0000;
      end
    end else begin
      for (int w = 0; w < LINE_SIZE; w++) begin
        if (latch_wline_s) begin
          wline_q[w] <= wr_line[w];
        end
        if (rd_load_s) begin
          rd_line_q[w] <= mem_q[rd_addr_s][w];
        end
      end
    end
  end

  // Line storage; reset restores the address-derived init pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NUM_LINES; a++) begin
        for (int w = 0; w < LINE_SIZE; w++) begin
          mem_q[a][w] <= 32'((a << LINE_ADDR_LEN) | w);
        end
      end
    end else if (wr_commit_s) begin
      for (int w = 0; w < LINE_SIZE; w++) begin
        mem_q[addr_q][w] <= wline_q[w];
      end
    end
  end

  assign gnt     = gnt_q;
  assign rd_line = rd_line_q;

endmodule
